// File: rtl/tim_ram_gen_if.sv
// Access bus for tim_ram_gen: E/WE/BE/Addr/DI request side, DO/VLD/BUSY response side.
interface tim_ram_gen_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          E;
  logic          WE;
  logic [DW/8-1:0] BE;
  logic [AW-1:0] Addr;
  logic [DW-1:0] DI;
  logic [DW-1:0] DO;
  logic          VLD;
  logic          CLR;
  logic          BUSY;

  modport master (output E, WE, BE, Addr, DI, CLR, input DO, VLD, BUSY);
  modport slave  (input E, WE, BE, Addr, DI, CLR, output DO, VLD, BUSY);
endinterface

// File: rtl/tim_ram_gen.sv
// Single-port RAM with byte enables, selectable read-during-write and a zeroing engine.
// Define TIM_RAM_OUTREG_EN for an extra output register stage (latency 2).
module tim_ram_gen #(
  parameter int DW       = 8,
  parameter int AW       = 4,
  parameter int RDW_MODE = 0
) (
  input logic          clk,
  input logic          rst_n,
  tim_ram_gen_if.slave bus
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {INIT, IDLE} state_t;

  state_t        state_reg;
  logic [AW-1:0] cnt_reg;
  logic          busy_reg;
  logic [DW-1:0] do_reg;
  logic          vld_reg;

  logic [DW-1:0] mem [DEPTH];

  logic          acc;
  logic [NB-1:0] wr_be;
  logic [DW-1:0] rd_old;
  logic [DW-1:0] rd_new;

  // A CLR in IDLE wins over a simultaneous access.
  assign acc    = (state_reg == IDLE) && !bus.CLR && bus.E;
  assign wr_be  = (acc && bus.WE) ? bus.BE : '0;
  assign rd_old = mem[bus.Addr];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign rd_new[8*gi +: 8] = wr_be[gi] ? bus.DI[8*gi +: 8] : rd_old[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        INIT: begin
          cnt_reg <= cnt_reg + AW'(1);
          if (cnt_reg == '1) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          if (bus.CLR) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Array has no reset; the clear engine owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (state_reg == INIT) begin
      mem[cnt_reg] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) mem[bus.Addr][8*i +: 8] <= bus.DI[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_reg  <= '0;
      vld_reg <= 1'b0;
    end else begin
      vld_reg <= acc;
      if (acc) do_reg <= (RDW_MODE != 0) ? rd_new : rd_old;
    end
  end

`ifdef TIM_RAM_OUTREG_EN
  logic [DW-1:0] do2_reg;
  logic          vld2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do2_reg  <= '0;
      vld2_reg <= 1'b0;
    end else begin
      do2_reg  <= do_reg;
      vld2_reg <= vld_reg;
    end
  end

  assign bus.DO  = do2_reg;
  assign bus.VLD = vld2_reg;
`else
  assign bus.DO  = do_reg;
  assign bus.VLD = vld_reg;
`endif

  assign bus.BUSY = busy_reg;
endmodule

// File: tb/tb_tim_ram_gen.sv
// Directed bench: two 16-bit instances (read-first and write-first) driven in lockstep.
module tb_tim_ram_gen;
`ifdef TIM_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  tim_ram_gen_if #(.DW(16), .AW(4)) bus0 ();
  tim_ram_gen_if #(.DW(16), .AW(4)) bus1 ();

  tim_ram_gen #(.DW(16), .AW(4), .RDW_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  tim_ram_gen #(.DW(16), .AW(4), .RDW_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic        e;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  addr;
    logic [15:0] di;
    logic        vld;
    logic [15:0] do0;
    logic [15:0] do1;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  task automatic drive(input logic e, input logic we, input logic [1:0] be,
                       input logic [3:0] addr, input logic [15:0] di, input logic clr);
    bus0.E = e;  bus0.WE = we;  bus0.BE = be;  bus0.Addr = addr;  bus0.DI = di;  bus0.CLR = clr;
    bus1.E = e;  bus1.WE = we;  bus1.BE = be;  bus1.Addr = addr;  bus1.DI = di;  bus1.CLR = clr;
  endtask

  // Called at a negedge; counts rising edges while BUSY is high.
  task automatic measure_busy(input int pulse_at, input bit zero_chk, output int n, output bit bad);
    n   = 0;
    bad = 1'b0;
    while (bus0.BUSY === 1'b1 && n < 100) begin
      if (bus0.VLD !== 1'b0 || bus1.VLD !== 1'b0) bad = 1'b1;
      if (zero_chk && (bus0.DO !== 16'h0 || bus1.DO !== 16'h0)) bad = 1'b1;
      if (bus1.BUSY !== 1'b1) bad = 1'b1;
      bus0.CLR = (n == pulse_at);
      bus1.CLR = (n == pulse_at);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus0.CLR = 1'b0;
    bus1.CLR = 1'b0;
  endtask

  task automatic read_check(input string nm, input logic [3:0] addr, input logic [15:0] exp);
    @(negedge clk);
    drive(1, 0, 2'b00, addr, 16'h0, 0);
    @(posedge clk);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
      @(posedge clk);
    end
    #1;
    chk({nm, "_vld"}, {15'd0, bus0.VLD}, 16'd1);
    chk({nm, "_do0"}, bus0.DO, exp);
    chk({nm, "_do1"}, bus1.DO, exp);
    @(negedge clk);
    drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
  endtask

  task automatic fill_ff();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      drive(1, 1, 2'b11, 4'(a), 16'hFFFF, 0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
    repeat (LAT + 1) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit bad;
    bit zero_bad;

    vecs[0]  = '{1, 1, 2'b01, 4'd3, 16'h00A5, 1, 16'h0000, 16'h00A5};
    vecs[1]  = '{1, 0, 2'b00, 4'd3, 16'h0000, 1, 16'h00A5, 16'h00A5};
    vecs[2]  = '{0, 0, 2'b00, 4'd0, 16'h0000, 0, 16'h00A5, 16'h00A5};
    vecs[3]  = '{1, 1, 2'b11, 4'd5, 16'h1234, 1, 16'h0000, 16'h1234};
    vecs[4]  = '{1, 1, 2'b10, 4'd5, 16'hFF00, 1, 16'h1234, 16'hFF34};
    vecs[5]  = '{1, 0, 2'b00, 4'd5, 16'h0000, 1, 16'hFF34, 16'hFF34};
    vecs[6]  = '{1, 1, 2'b11, 4'd7, 16'h0011, 1, 16'h0000, 16'h0011};
    vecs[7]  = '{1, 1, 2'b11, 4'd7, 16'h0022, 1, 16'h0011, 16'h0022};
    vecs[8]  = '{1, 0, 2'b00, 4'd7, 16'h0000, 1, 16'h0022, 16'h0022};
    vecs[9]  = '{1, 1, 2'b00, 4'd5, 16'hAAAA, 1, 16'hFF34, 16'hFF34};
    vecs[10] = '{1, 0, 2'b00, 4'd5, 16'h0000, 1, 16'hFF34, 16'hFF34};
    vecs[11] = '{0, 1, 2'b11, 4'd5, 16'h0000, 0, 16'hFF34, 16'hFF34};
    vecs[12] = '{1, 0, 2'b00, 4'd5, 16'h0000, 1, 16'hFF34, 16'hFF34};
    vecs[13] = '{1, 0, 2'b00, 4'd15, 16'h0000, 1, 16'h0000, 16'h0000};

    // Reset and initial clear
    rst_n = 1'b0;
    drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {15'd0, bus0.BUSY}, 16'd1);
    chk("rst_vld", {15'd0, bus0.VLD}, 16'd0);
    chk("rst_do", bus0.DO, 16'h0);
    rst_n = 1'b1;
    measure_busy(-1, 1'b1, n, bad);
    chk("init_busy_edges", 16'(n), 16'd16);
    chk("init_quiet", {15'd0, bad}, 16'd0);
    chk("init_busy_low", {15'd0, bus0.BUSY}, 16'd0);

    // Table-driven access vectors, outputs checked LAT edges after each vector
    for (int k = 0; k < NV + LAT - 1; k++) begin
      @(negedge clk);
      if (k < NV) drive(vecs[k].e, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].di, 0);
      else        drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
      @(posedge clk);
      #1;
      if (k >= LAT - 1) begin
        chk($sformatf("vec%0d_vld", k - LAT + 1), {15'd0, bus0.VLD}, {15'd0, vecs[k - LAT + 1].vld});
        chk($sformatf("vec%0d_do0", k - LAT + 1), bus0.DO, vecs[k - LAT + 1].do0);
        chk($sformatf("vec%0d_do1", k - LAT + 1), bus1.DO, vecs[k - LAT + 1].do1);
      end
    end
    @(negedge clk);
    drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
    repeat (2) @(posedge clk);

    // Clear while full: CLR beats a simultaneous write; CLR inside INIT is ignored
    fill_ff();
    read_check("full_a9", 4'd9, 16'hFFFF);
    @(negedge clk);
    drive(1, 1, 2'b11, 4'd0, 16'h1234, 1);
    @(posedge clk);
    #1;
    chk("clr_busy", {15'd0, bus0.BUSY}, 16'd1);
    @(negedge clk);
    drive(1, 0, 2'b00, 4'd0, 16'h0, 0);
    measure_busy(5, 1'b0, n, bad);
    drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
    chk("clr_busy_edges", 16'(n), 16'd16);
    chk("clr_no_vld", {15'd0, bad}, 16'd0);
    for (int a = 0; a < 16; a++) read_check($sformatf("clr_a%0d", a), 4'(a), 16'h0000);

    // Reset during the clear restarts it from address 0
    fill_ff();
    @(negedge clk);
    drive(0, 0, 2'b00, 4'd0, 16'h0, 1);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 2'b00, 4'd0, 16'h0, 0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {15'd0, bus0.BUSY}, 16'd1);
    zero_bad = (bus0.DO !== 16'h0) || (bus1.DO !== 16'h0) || (bus0.VLD !== 1'b0);
    chk("mid_rst_outs", {15'd0, zero_bad}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    measure_busy(-1, 1'b1, n, bad);
    chk("mid_rst_busy_edges", 16'(n), 16'd16);
    for (int a = 0; a < 16; a++) read_check($sformatf("rst_a%0d", a), 4'(a), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tim_ram_gen.md
# tim_ram_gen

Parametrised single-port synchronous RAM with byte write enables, a selectable read-during-write mode, and a built-in clear engine. A hardware state machine zeroes every word after reset or on request. It is the general-purpose on-chip storage block for small lookup tables and scratch buffers; its E/WE/Addr/DI/DO access style is unchanged from the team's earlier fixed 8-bit RAM.

## Interface
Parameters:
- DW, 8, data width in bits; must be a multiple of 8.
- AW, 4, address width; depth = 2**AW words.
- RDW_MODE, 0, read-during-write behaviour on the same address: 0 = read-first (old data), 1 = write-first (new data, byte-merged).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- E  in  1  access enable.
- WE  in  1  write enable, qualified by E.
- BE  in  DW/8  byte write enables; bit i covers DI[8i+7:8i].
- Addr  in  AW  word address.
- DI  in  DW  write data.
- DO  out  DW  registered read data.
- VLD  out  1  DO carries data from an accepted read.
- CLR  in  1  single-cycle request to zero the whole array.
- BUSY  out  1  clear engine active; accesses are ignored while high.

## Operation
- FSM states: INIT, IDLE.
- Reset asserted:
  - State forced to INIT; clear counter = 0.
  - DO = 0, VLD = 0, BUSY = 1.
  - Array contents are not reset asynchronously.
- INIT:
  - Each cycle writes all-zero to word[counter], then counter increments.
  - After writing word 2**AW-1, go to IDLE on the next edge; the counter wraps to 0.
  - BUSY = 1 throughout INIT.
- IDLE:
  - BUSY = 0.
  - CLR = 1 → INIT with counter = 0.
  - A CLR in the same cycle as an access takes priority; the access is dropped.
- Access is accepted only when state = IDLE, CLR = 0 and E = 1.
- Accepted write (WE = 1): for each i with BE[i] = 1, word[Addr] byte i ← DI byte i. Bytes with BE[i] = 0 are unchanged. WE = 1 with BE = 0 writes nothing.
- Every accepted access also performs a read:
  - DO ← word[Addr].
  - On a write, the RDW_MODE rule applies: mode 1 returns the merged new word; mode 0 returns the pre-write word.
- VLD is 1 for exactly the cycle following each accepted access, else 0.
- DO holds its last value when no access is accepted, including during INIT.
- CLR while in INIT: ignored; the clear continues.
- Reset asserted mid-clear: the clear restarts from address 0.

## Timing
- Read latency: 1 cycle. DO/VLD update on the edge that samples E = 1.
- Back-to-back accesses are allowed every cycle, no bubbles.
- Clear duration: BUSY is high for exactly 2**AW rising edges after reset release, or after the CLR edge. IDLE accesses are accepted on the first edge where BUSY was sampled 0.
- No combinational path from inputs to outputs.

## Configuration
- TIM_RAM_OUTREG_EN defined:
  - Adds a second output register stage after the array read.
  - DO/VLD latency becomes 2 cycles.
  - Both stages reset to 0.
  - Throughput is still one access per cycle.
  - The RDW_MODE result is carried unchanged through the extra stage.
- Not defined: single-stage output, latency 1, as above.

## Test plan
- Reset release, AW = 4: BUSY = 1 for 16 cycles, then 0; DO = 0 and VLD = 0 throughout.
- Write 0xA5 to Addr 3 (BE = 1), then read Addr 3: next cycle DO = 0xA5, VLD = 1; the following idle cycle VLD = 0 and DO holds 0xA5.
- Byte enables, DW = 16:
  - Write 0x1234 with BE = 11; write 0xFF00 with BE = 10.
  - Read returns 0xFF34.
- Read-during-write: word = 0x11, write 0x22 to the same address.
  - RDW_MODE = 0: DO = 0x11.
  - RDW_MODE = 1: DO = 0x22.
  - Subsequent read returns 0x22 in both modes.
- Clear while full:
  - Fill all 16 words with 0xFF.
  - Pulse CLR together with E = 1, WE = 1 on Addr 0: the write is dropped and BUSY = 1 for 16 cycles.
  - Accesses during BUSY give VLD = 0.
  - Afterwards every address reads 0x00.
- Reset mid-clear: assert rst_n = 0 at cycle 7 of INIT. After release, BUSY = 1 for a full 16 cycles, then all words read 0.
- With TIM_RAM_OUTREG_EN defined, repeat the read test: DO = 0xA5 and VLD = 1 appear two cycles after the access.
